// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares a single memory port between the instruction fetch unit and the
// load/store unit. Only one transaction is in flight at a time. Requests
// use valid/ready handshakes and responses are single-cycle pulses routed
// back to whichever requester owns the current transaction.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,

    // instruction fetch requester
    input  logic                    ifu_req_valid,
    output logic                    ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0]   ifu_addr,
    output logic                    ifu_resp_valid,
    output logic [DATA_WIDTH-1:0]   ifu_rdata,

    // load/store requester
    input  logic                    lsu_req_valid,
    output logic                    lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0]   lsu_addr,
    input  logic                    lsu_wen,
    input  logic [DATA_WIDTH-1:0]   lsu_wdata,
    input  logic [DATA_WIDTH/8-1:0] lsu_wmask,
    output logic                    lsu_resp_valid,
    output logic [DATA_WIDTH-1:0]   lsu_rdata,

    // shared memory port
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_wen,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    input  logic                    mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,

    output logic                    busy
);

    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    localparam logic OWNER_IFU = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic                    owner_reg;
    logic                    owner_next;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [ADDR_WIDTH-1:0]   addr_next;
    logic                    wen_reg;
    logic                    wen_next;
    logic [DATA_WIDTH-1:0]   wdata_reg;
    logic [DATA_WIDTH-1:0]   wdata_next;
    logic [MASK_WIDTH-1:0]   wmask_reg;
    logic [MASK_WIDTH-1:0]   wmask_next;

    logic                    grant_lsu;
    logic                    grant_ifu;
    logic                    accept;
    logic                    resp_fire;

    // Fixed-priority grant in IDLE: the core is stalled on the LSU, so it wins.
    // Reset gates the grants so no ready is visible while rst is high.
    always_comb begin
        grant_lsu = (state_reg == IDLE) && lsu_req_valid && !rst;
        grant_ifu = (state_reg == IDLE) && ifu_req_valid && !lsu_req_valid && !rst;
        accept    = grant_lsu || grant_ifu;
        resp_fire = (state_reg == WAIT) && mem_resp_valid;
    end

    // State register; reset drops any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: responses outside WAIT are stale and ignored.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the winner's command; an IFU fetch is always a full-word read.
    always_comb begin
        owner_next = owner_reg;
        addr_next  = addr_reg;
        wen_next   = wen_reg;
        if (grant_lsu) begin
            owner_next = OWNER_LSU;
            addr_next  = lsu_addr;
            wen_next   = lsu_wen;
        end else if (grant_ifu) begin
            owner_next = OWNER_IFU;
            addr_next  = ifu_addr;
            wen_next   = 1'b0;
        end
    end

    // Per-byte-lane capture of store data and byte enables.
    generate
        for (genvar gi = 0; gi < MASK_WIDTH; gi++) begin : g_lane
            always_comb begin
                wdata_next[gi*8 +: 8] = wdata_reg[gi*8 +: 8];
                wmask_next[gi]        = wmask_reg[gi];
                if (grant_lsu) begin
                    wdata_next[gi*8 +: 8] = lsu_wdata[gi*8 +: 8];
                    wmask_next[gi]        = lsu_wmask[gi];
                end else if (grant_ifu) begin
                    wdata_next[gi*8 +: 8] = 8'h00;
                    wmask_next[gi]        = 1'b0;
                end
            end
        end
    endgenerate

    // Command latches hold mem_* stable from accept until the next grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_reg <= OWNER_IFU;
            addr_reg  <= '0;
            wen_reg   <= 1'b0;
            wdata_reg <= '0;
            wmask_reg <= '0;
        end else begin
            owner_reg <= owner_next;
            addr_reg  <= addr_next;
            wen_reg   <= wen_next;
            wdata_reg <= wdata_next;
            wmask_reg <= wmask_next;
        end
    end

    // Outputs: handshakes, memory command and the owner-routed response pulse.
    always_comb begin
        ifu_req_ready  = grant_ifu;
        lsu_req_ready  = grant_lsu;
        mem_req_valid  = (state_reg == REQ);
        mem_addr       = addr_reg;
        mem_wen        = wen_reg;
        mem_wdata      = wdata_reg;
        mem_wmask      = wmask_reg;
        busy           = (state_reg != IDLE);
        ifu_resp_valid = 1'b0;
        ifu_rdata      = '0;
        lsu_resp_valid = 1'b0;
        lsu_rdata      = '0;
        if (resp_fire) begin
            if (owner_reg == OWNER_LSU) begin
                lsu_resp_valid = 1'b1;
                lsu_rdata      = mem_rdata;
            end else begin
                ifu_resp_valid = 1'b1;
                ifu_rdata      = mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Inputs change 1 time unit after
// the rising edge; outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            ifu_req_valid;
    logic            ifu_req_ready;
    logic [AW-1:0]   ifu_addr;
    logic            ifu_resp_valid;
    logic [DW-1:0]   ifu_rdata;
    logic            lsu_req_valid;
    logic            lsu_req_ready;
    logic [AW-1:0]   lsu_addr;
    logic            lsu_wen;
    logic [DW-1:0]   lsu_wdata;
    logic [DW/8-1:0] lsu_wmask;
    logic            lsu_resp_valid;
    logic [DW-1:0]   lsu_rdata;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [AW-1:0]   mem_addr;
    logic            mem_wen;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_wmask;
    logic            mem_resp_valid;
    logic [DW-1:0]   mem_rdata;
    logic            busy;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_addr(ifu_addr), .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_addr(lsu_addr), .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata),
        .lsu_wmask(lsu_wmask), .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic check_quiet_resp(input string tag);
        check({tag, ".ifu_resp_valid"}, 64'(ifu_resp_valid), 64'd0);
        check({tag, ".lsu_resp_valid"}, 64'(lsu_resp_valid), 64'd0);
    endtask

    initial begin
        rst            = 1'b1;
        ifu_req_valid  = 1'b0;
        ifu_addr       = '0;
        lsu_req_valid  = 1'b0;
        lsu_addr       = '0;
        lsu_wen        = 1'b0;
        lsu_wdata      = '0;
        lsu_wmask      = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;

        // reset state
        ifu_req_valid = 1'b1;
        sample();
        check("rst.ifu_req_ready", 64'(ifu_req_ready), 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.mem_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst.mem_addr", 64'(mem_addr), 64'd0);
        cyc();
        rst = 1'b0;
        ifu_req_valid = 1'b0;

        // ---- 1: IFU fetch, memory ready at once, response next cycle
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0000;
        sample();
        check("t1.ifu_req_ready", 64'(ifu_req_ready), 64'd1);
        check("t1.lsu_req_ready", 64'(lsu_req_ready), 64'd0);
        check("t1.busy_accept", 64'(busy), 64'd0);
        cyc();
        ifu_req_valid = 1'b0;
        ifu_addr      = 32'h0;
        mem_req_ready = 1'b1;
        sample();
        check("t1.mem_req_valid", 64'(mem_req_valid), 64'd1);
        check("t1.mem_addr", 64'(mem_addr), 64'h8000_0000);
        check("t1.mem_wen", 64'(mem_wen), 64'd0);
        check("t1.mem_wmask", 64'(mem_wmask), 64'd0);
        check("t1.ifu_req_ready_req", 64'(ifu_req_ready), 64'd0);
        cyc();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h0010_0073;
        sample();
        check("t1.ifu_resp_valid", 64'(ifu_resp_valid), 64'd1);
        check("t1.ifu_rdata", 64'(ifu_rdata), 64'h0010_0073);
        check("t1.lsu_resp_valid", 64'(lsu_resp_valid), 64'd0);
        check("t1.lsu_rdata", 64'(lsu_rdata), 64'd0);
        cyc();
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        sample();
        check_quiet_resp("t1.after");
        check("t1.busy_after", 64'(busy), 64'd0);
        check("t1.ifu_rdata_idle", 64'(ifu_rdata), 64'd0);

        // ---- 2: simultaneous requests, LSU store wins
        cyc();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0004;
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_1000;
        lsu_wen       = 1'b1;
        lsu_wdata     = 32'hDEAD_BEEF;
        lsu_wmask     = 4'hF;
        sample();
        check("t2.lsu_req_ready", 64'(lsu_req_ready), 64'd1);
        check("t2.ifu_req_ready", 64'(ifu_req_ready), 64'd0);
        cyc();
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        sample();
        check("t2.mem_addr", 64'(mem_addr), 64'h8000_1000);
        check("t2.mem_wen", 64'(mem_wen), 64'd1);
        check("t2.mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
        check("t2.mem_wmask", 64'(mem_wmask), 64'hF);
        check("t2.ifu_req_ready_req", 64'(ifu_req_ready), 64'd0);
        cyc();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        sample();
        check("t2.lsu_resp_valid", 64'(lsu_resp_valid), 64'd1);
        check("t2.ifu_resp_valid", 64'(ifu_resp_valid), 64'd0);
        check("t2.ifu_req_ready_wait", 64'(ifu_req_ready), 64'd0);
        cyc();
        mem_resp_valid = 1'b0;
        sample();
        check("t2.ifu_granted", 64'(ifu_req_ready), 64'd1);
        cyc();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        sample();
        check("t2.ifu_mem_addr", 64'(mem_addr), 64'h8000_0004);
        check("t2.ifu_mem_wen", 64'(mem_wen), 64'd0);
        check("t2.ifu_mem_wmask", 64'(mem_wmask), 64'd0);
        check("t2.ifu_mem_wdata", 64'(mem_wdata), 64'd0);
        cyc();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hCAFE_0001;
        sample();
        check("t2.ifu_resp_valid", 64'(ifu_resp_valid), 64'd1);
        check("t2.ifu_rdata", 64'(ifu_rdata), 64'hCAFE_0001);
        cyc();
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;

        // ---- 3: memory stalls 5 cycles in REQ, LSU payload changes after accept
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_2000;
        lsu_wen       = 1'b1;
        lsu_wdata     = 32'h1111_2222;
        lsu_wmask     = 4'h3;
        sample();
        check("t3.lsu_req_ready", 64'(lsu_req_ready), 64'd1);
        cyc();
        lsu_addr  = 32'h9000_0000;
        lsu_wdata = 32'h3333_4444;
        lsu_wmask = 4'hC;
        lsu_wen   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample();
            check($sformatf("t3.stall%0d.mem_req_valid", i), 64'(mem_req_valid), 64'd1);
            check($sformatf("t3.stall%0d.mem_addr", i), 64'(mem_addr), 64'h8000_2000);
            check($sformatf("t3.stall%0d.mem_wdata", i), 64'(mem_wdata), 64'h1111_2222);
            check($sformatf("t3.stall%0d.mem_wmask", i), 64'(mem_wmask), 64'h3);
            check($sformatf("t3.stall%0d.lsu_req_ready", i), 64'(lsu_req_ready), 64'd0);
            cyc();
        end
        mem_req_ready = 1'b1;
        sample();
        check("t3.mem_addr_accept", 64'(mem_addr), 64'h8000_2000);
        cyc();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        sample();
        check("t3.lsu_req_ready_wait", 64'(lsu_req_ready), 64'd0);
        check("t3.lsu_resp_valid", 64'(lsu_resp_valid), 64'd1);
        cyc();
        mem_resp_valid = 1'b0;
        lsu_req_valid  = 1'b0;
        lsu_wen        = 1'b0;

        // ---- 4: stray responses in IDLE and REQ are ignored
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hBAD0_BAD0;
        sample();
        check_quiet_resp("t4.idle");
        check("t4.idle_busy", 64'(busy), 64'd0);
        cyc();
        sample();
        check("t4.idle_busy2", 64'(busy), 64'd0);
        check("t4.idle_mem_req_valid", 64'(mem_req_valid), 64'd0);
        cyc();
        mem_resp_valid = 1'b0;
        ifu_req_valid  = 1'b1;
        ifu_addr       = 32'h8000_0010;
        cyc();
        ifu_req_valid  = 1'b0;
        mem_resp_valid = 1'b1;
        sample();
        check_quiet_resp("t4.req");
        check("t4.req_busy", 64'(busy), 64'd1);
        cyc();
        sample();
        check("t4.still_req", 64'(mem_req_valid), 64'd1);
        check_quiet_resp("t4.req2");
        cyc();
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b1;
        cyc();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h0000_00AA;
        sample();
        check("t4.ifu_resp_valid", 64'(ifu_resp_valid), 64'd1);
        check("t4.ifu_rdata", 64'(ifu_rdata), 64'hAA);
        cyc();
        mem_resp_valid = 1'b0;

        // ---- 5: reset in the middle of WAIT
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0020;
        cyc();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        cyc();
        mem_req_ready = 1'b0;
        ifu_req_valid = 1'b1;
        sample();
        check("t5.busy_wait", 64'(busy), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t5.rst_busy", 64'(busy), 64'd0);
        check("t5.rst_ifu_req_ready", 64'(ifu_req_ready), 64'd0);
        check("t5.rst_mem_addr", 64'(mem_addr), 64'd0);
        check("t5.rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        cyc();
        cyc();
        rst            = 1'b0;
        ifu_req_valid  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h5555_5555;
        sample();
        check_quiet_resp("t5.late");
        check("t5.late_busy", 64'(busy), 64'd0);
        cyc();
        mem_resp_valid = 1'b0;
        ifu_req_valid  = 1'b1;
        ifu_addr       = 32'h8000_0030;
        sample();
        check("t5.ifu_req_ready", 64'(ifu_req_ready), 64'd1);
        cyc();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        sample();
        check("t5.mem_addr", 64'(mem_addr), 64'h8000_0030);
        cyc();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h0000_1234;
        sample();
        check("t5.ifu_resp_valid", 64'(ifu_resp_valid), 64'd1);
        check("t5.ifu_rdata", 64'(ifu_rdata), 64'h1234);
        cyc();
        mem_resp_valid = 1'b0;

        // ---- 6: LSU load with 3-cycle memory latency
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_3000;
        lsu_wen       = 1'b0;
        sample();
        check("t6.lsu_req_ready", 64'(lsu_req_ready), 64'd1);
        check("t6.busy_accept", 64'(busy), 64'd0);
        cyc();
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        sample();
        check("t6.busy_req", 64'(busy), 64'd1);
        check("t6.mem_wen", 64'(mem_wen), 64'd0);
        cyc();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sample();
            check($sformatf("t6.wait%0d.busy", i), 64'(busy), 64'd1);
            check($sformatf("t6.wait%0d.lsu_resp_valid", i), 64'(lsu_resp_valid), 64'd0);
            cyc();
        end
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h1234_5678;
        sample();
        check("t6.lsu_resp_valid", 64'(lsu_resp_valid), 64'd1);
        check("t6.lsu_rdata", 64'(lsu_rdata), 64'h1234_5678);
        check("t6.ifu_resp_valid", 64'(ifu_resp_valid), 64'd0);
        check("t6.busy_resp", 64'(busy), 64'd1);
        cyc();
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        sample();
        check("t6.busy_after", 64'(busy), 64'd0);
        check("t6.lsu_resp_after", 64'(lsu_resp_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
